rc_filter_channel_sequencer: RTL and testbench

Time-multiplexed controller that shares one RC high-pass update datapath among `CHANNELS` audio channels. On each audio sample strobe it snapshots all channel inputs and steps a single multiply-accumulate through the channels in order. It holds per-channel filter state (previous input, previous output) and a runtime-configurable per-channel smoothing factor alpha. It sits between the per-circuit discrete stages and the mixer, replacing one filter instance per channel.

---
 rtl/rc_filter_pkg.sv | 28 ++
 rtl/rc_high_pass_mac.sv | 31 +++
 rtl/rc_filter_channel_sequencer.sv | 105 ++++++++++
 tb/tb_rc_filter_channel_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rc_filter_pkg.sv
// rtl/rc_filter_pkg.sv - shared widths, FSM states and saturation helper for the RC filter sequencer
package rc_filter_pkg;

   localparam int SAMPLE_W = 16;
   localparam int ALPHA_W  = 16;
   localparam int DIFF_W   = 18;
   localparam int PROD_W   = 35;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

   // Clamp an already-shifted product into the signed 16-bit sample range.
   function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [PROD_W-1:0] v);
      logic signed [SAMPLE_W-1:0] r;
      if (v > 35'sd32767)
         r = 16'sh7FFF;
      else if (v < -35'sd32768)
         r = 16'sh8000;
      else
         r = v[SAMPLE_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/rc_high_pass_mac.sv
// rtl/rc_high_pass_mac.sv - shared RC high-pass multiply stage: prod = alpha * (prev_out + in - prev_in)
module rc_high_pass_mac
   import rc_filter_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load,
   input  logic [ALPHA_W-1:0]         alpha,
   input  logic signed [SAMPLE_W-1:0] prev_out,
   input  logic signed [SAMPLE_W-1:0] in,
   input  logic signed [SAMPLE_W-1:0] prev_in,
   output logic signed [PROD_W-1:0]   prod
);

   logic signed [DIFF_W-1:0]  diff;
   logic signed [ALPHA_W:0]   alpha_s;

   // 18 bits hold the full range of a three-term sum of 16-bit samples.
   assign diff    = {{2{prev_out[SAMPLE_W-1]}}, prev_out}
                  + {{2{in[SAMPLE_W-1]}}, in}
                  - {{2{prev_in[SAMPLE_W-1]}}, prev_in};
   assign alpha_s = {1'b0, alpha};

   always_ff @(posedge clk) begin
      if (reset)
         prod <= '0;
      else if (load)
         prod <= alpha_s * diff;
   end

endmodule

// File: rtl/rc_filter_channel_sequencer.sv
// rtl/rc_filter_channel_sequencer.sv - time-multiplexed RC high-pass filter across CHANNELS audio channels
module rc_filter_channel_sequencer
   import rc_filter_pkg::*;
#(
   parameter int                 CHANNELS      = 4,
   parameter logic [ALPHA_W-1:0] DEFAULT_ALPHA = 16'd64924
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          audio_clk_en,
   input  logic [SAMPLE_W*CHANNELS-1:0]  in_flat,
   input  logic                          cfg_we,
   input  logic [$clog2(CHANNELS)-1:0]   cfg_ch,
   input  logic [ALPHA_W-1:0]            cfg_alpha,
   output logic [SAMPLE_W*CHANNELS-1:0]  out_flat,
   output logic                          out_valid,
   output logic                          busy,
   output logic                          overrun
);

   localparam int CH_W = $clog2(CHANNELS);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

   seq_state_t state, state_nxt;
   logic [CH_W-1:0] ch;
   logic            mac_load;

   logic signed [SAMPLE_W-1:0] snap     [CHANNELS];
   logic signed [SAMPLE_W-1:0] prev_in  [CHANNELS];
   logic signed [SAMPLE_W-1:0] prev_out [CHANNELS];
   logic [ALPHA_W-1:0]         alpha_tab[CHANNELS];

   logic signed [PROD_W-1:0]   prod;
   logic signed [SAMPLE_W-1:0] y_sat;

   rc_high_pass_mac u_mac (
      .clk      (clk),
      .reset    (reset),
      .load     (mac_load),
      .alpha    (alpha_tab[ch]),
      .prev_out (prev_out[ch]),
      .in       (snap[ch]),
      .prev_in  (prev_in[ch]),
      .prod     (prod)
   );

   assign y_sat = sat16(prod >>> 16);
   assign busy  = (state != IDLE);

   always_comb begin
      state_nxt = state;
      mac_load  = 1'b0;
      case (state)
         IDLE:  if (audio_clk_en) state_nxt = CALC;
         CALC:  begin
                   mac_load  = 1'b1;
                   state_nxt = WRITE;
                end
         WRITE: state_nxt = (ch == LAST_CH) ? DONE : CALC;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ch        <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         out_flat  <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            snap[k]      <= '0;
            prev_in[k]   <= '0;
            prev_out[k]  <= '0;
            alpha_tab[k] <= DEFAULT_ALPHA;
         end
      end else begin
         state     <= state_nxt;
         out_valid <= (state == DONE);
         if (audio_clk_en && (state != IDLE))
            overrun <= 1'b1;
         // The MAC has already sampled the old alpha on this edge, so a colliding write lands next frame.
         if (cfg_we && (int'(cfg_ch) < CHANNELS))
            alpha_tab[cfg_ch] <= cfg_alpha;
         case (state)
            IDLE: if (audio_clk_en) begin
                     ch <= '0;
                     for (int k = 0; k < CHANNELS; k++)
                        snap[k] <= in_flat[SAMPLE_W*k +: SAMPLE_W];
                  end
            WRITE: begin
                     prev_out[ch] <= y_sat;
                     prev_in[ch]  <= snap[ch];
                     if (ch != LAST_CH)
                        ch <= ch + 1'b1;
                  end
            DONE: for (int k = 0; k < CHANNELS; k++)
                     out_flat[SAMPLE_W*k +: SAMPLE_W] <= prev_out[k];
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rc_filter_channel_sequencer.sv
// tb/tb_rc_filter_channel_sequencer.sv - scoreboard bench for rc_filter_channel_sequencer
module tb_rc_filter_channel_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        audio_clk_en = 1'b0;
   logic [63:0] in_flat = '0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_ch = '0;
   logic [15:0] cfg_alpha = '0;
   logic [63:0] out_flat;
   logic        out_valid;
   logic        busy;
   logic        overrun;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct packed {
      logic [63:0] exp_out;
      int          exp_cyc;
   } exp_t;
   exp_t sb_q[$];

   rc_filter_channel_sequencer #(.CHANNELS(4), .DEFAULT_ALPHA(16'd64924)) dut (
      .clk          (clk),
      .reset        (reset),
      .audio_clk_en (audio_clk_en),
      .in_flat      (in_flat),
      .cfg_we       (cfg_we),
      .cfg_ch       (cfg_ch),
      .cfg_alpha    (cfg_alpha),
      .out_flat     (out_flat),
      .out_valid    (out_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] pack4(input logic [15:0] c0, input logic [15:0] c1,
                                         input logic [15:0] c2, input logic [15:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: every out_valid pulse must match the oldest pending expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && out_valid) begin
            if (sb_q.size() == 0) begin
               check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
               e = sb_q.pop_front();
               check("out_flat", out_flat, e.exp_out);
               check("valid_latency", 64'(cyc), 64'(e.exp_cyc));
               check("busy_at_valid", {63'd0, busy}, 64'd0);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      idle(n);
      reset = 1'b0;
   endtask

   task automatic cfg(input logic [1:0] c, input logic [15:0] a);
      @(negedge clk);
      cfg_we = 1'b1; cfg_ch = c; cfg_alpha = a;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Strobe sampled on the next posedge E; returns at the negedge just after E.
   task automatic strobe(input logic [63:0] vec, input logic [63:0] exp, input bit expect_out);
      @(negedge clk);
      in_flat = vec;
      audio_clk_en = 1'b1;
      if (expect_out) sb_q.push_back('{exp_out: exp, exp_cyc: cyc + 10});
      @(negedge clk);
      audio_clk_en = 1'b0;
   endtask

   initial begin
      // Reset state
      do_reset(2);
      @(negedge clk);
      check("reset_out_flat", out_flat, 64'd0);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_overrun", {63'd0, overrun}, 64'd0);
      check("reset_out_valid", {63'd0, out_valid}, 64'd0);

      // First frame with default alpha
      strobe(pack4(16'd1000, 16'd0, 16'd0, 16'd0), pack4(16'd990, 16'd0, 16'd0, 16'd0), 1'b1);
      check("busy_in_frame", {63'd0, busy}, 64'd1);
      idle(12);

      // Basic decay, second strobe coincident with out_valid
      do_reset(1);
      cfg(2'd0, 16'd32768);
      strobe(pack4(16'd10000, 16'd0, 16'd0, 16'd0), pack4(16'd5000, 16'd0, 16'd0, 16'd0), 1'b1);
      idle(8);
      strobe(pack4(16'd10000, 16'd0, 16'd0, 16'd0), pack4(16'd2500, 16'd0, 16'd0, 16'd0), 1'b1);
      idle(12);
      check("no_overrun_min_spacing", {63'd0, overrun}, 64'd0);

      // Saturation on ch1
      do_reset(1);
      cfg(2'd1, 16'd65535);
      strobe(pack4(16'd0, 16'h8000, 16'd0, 16'd0), pack4(16'd0, 16'h8000, 16'd0, 16'd0), 1'b1);
      idle(12);
      strobe(pack4(16'd0, 16'h7FFF, 16'd0, 16'd0), pack4(16'd0, 16'h7FFE, 16'd0, 16'd0), 1'b1);
      idle(12);
      strobe(pack4(16'd0, 16'h8000, 16'd0, 16'd0), pack4(16'd0, 16'h8000, 16'd0, 16'd0), 1'b1);
      idle(12);

      // Overrun: extra strobe sampled at E+3 is ignored
      do_reset(1);
      strobe(pack4(16'd1000, 16'd0, 16'd0, 16'd0), pack4(16'd990, 16'd0, 16'd0, 16'd0), 1'b1);
      idle(1);
      strobe(pack4(16'd5000, 16'd0, 16'd0, 16'd0), 64'd0, 1'b0);
      idle(12);
      check("overrun_set", {63'd0, overrun}, 64'd1);
      strobe(pack4(16'd1000, 16'd0, 16'd0, 16'd0), pack4(16'd980, 16'd0, 16'd0, 16'd0), 1'b1);
      idle(12);
      check("overrun_sticky", {63'd0, overrun}, 64'd1);
      do_reset(1);
      @(negedge clk);
      check("overrun_cleared", {63'd0, overrun}, 64'd0);

      // Reset mid-frame at E+4
      strobe(pack4(16'd1000, 16'd0, 16'd0, 16'd0), 64'd0, 1'b0);
      idle(3);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midreset_out_flat", out_flat, 64'd0);
      check("midreset_busy", {63'd0, busy}, 64'd0);
      check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
      idle(12);
      strobe(pack4(16'd1000, 16'd0, 16'd0, 16'd0), pack4(16'd990, 16'd0, 16'd0, 16'd0), 1'b1);
      idle(12);

      // Alpha write to ch2 on its CALC edge (E+5)
      do_reset(1);
      cfg(2'd2, 16'd32768);
      strobe(pack4(16'd0, 16'd0, 16'd8000, 16'd0), pack4(16'd0, 16'd0, 16'd4000, 16'd0), 1'b1);
      idle(3);
      @(negedge clk);
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_alpha = 16'd0;
      @(negedge clk);
      cfg_we = 1'b0;
      idle(12);
      strobe(pack4(16'd0, 16'd0, 16'd8000, 16'd0), pack4(16'd0, 16'd0, 16'd0, 16'd0), 1'b1);
      idle(14);

      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
